uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two byte-stream requesters: req0 (debug_unit status/PC reporting) and req1 (CPU program-I/O write path).
- Grants the transmitter per frame: once a requester sends its first byte, it keeps the Tx until the byte flagged last completes.
- Sequences the Tx handshake: holds `tx_dato_in` stable, pulses `tx_start`, waits for `tx_done_tick`.
- Sits between the two requesters and the Tx instance inside the UART top.

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester frame arbiter in front of the UART transmitter
// Owner keeps the Tx until its last byte completes; ties go to the requester not served last.
module uart_tx_arbiter #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 200000,
  parameter int CNT_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_valid,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_valid,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic [DATA_W-1:0] tx_dato_in,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, FETCH, START, WAIT} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_served_q, last_served_d;
  logic                last_flag_q, last_flag_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic                own_valid;
  logic [DATA_W-1:0]   own_data;
  logic                own_last;
  logic                timeout_hit;

  assign own_valid   = owner_q ? req1_valid : req0_valid;
  assign own_data    = owner_q ? req1_data  : req0_data;
  assign own_last    = owner_q ? req1_last  : req0_last;
  assign timeout_hit = (cnt_q == CNT_W'(TX_TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    last_flag_d   = last_flag_q;
    data_d        = data_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d = (req0_valid && req1_valid) ? ~last_served_q : req1_valid;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // A handshake in the timeout cycle still wins: ready was already high.
        if (own_valid) begin
          data_d      = own_data;
          last_flag_d = own_last;
          state_d     = START;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          last_served_d = owner_q;
          timeout_err_d = 1'b1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (last_flag_q) begin
            state_d       = IDLE;
            last_served_d = owner_q;
          end else begin
            state_d = FETCH;
          end
        end else if (timeout_hit) begin
          state_d       = IDLE;
          last_served_d = owner_q;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == FETCH || state_q == WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      last_flag_q   <= 1'b0;
      data_q        <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      last_flag_q   <= last_flag_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req0_ready  = (state_q == FETCH) && !owner_q;
  assign req1_ready  = (state_q == FETCH) &&  owner_q;
  assign tx_start    = (state_q == START);
  assign tx_dato_in  = data_q;
  assign busy        = (state_q != IDLE);
  assign grant       = busy ? {owner_q, ~owner_q} : 2'b00;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
// Expected Tx bytes come from a frame-order model; a monitor pops them on every tx_start.
module tb_uart_tx_arbiter;
  localparam int DATA_W = 8;
  localparam int TO     = 50;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_valid, req1_valid, req0_last, req1_last;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] tx_dato_in;
  logic              tx_start, tx_done;
  logic [1:0]        grant;
  logic              busy, timeout_err;

  logic tx_done_m = 1'b0;
  logic tx_done_s = 1'b0;
  bit   tx_mute   = 1'b0;
  assign tx_done = tx_done_m | tx_done_s;

  uart_tx_arbiter #(.DATA_W(DATA_W), .TX_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_dato_in(tx_dato_in), .tx_start(tx_start), .tx_done(tx_done),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [1:0] g; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_ls = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or event not expected", name);
  endtask

  task automatic push_exp(input int r, input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.g = (r == 0) ? 2'b01 : 2'b10;
    exp_q.push_back(e);
  endtask

  // Frame order from the arbitration rule: both pending -> the one not served last.
  task automatic model_order(input logic [7:0] b0[$], input bit l0[$],
                             input logic [7:0] b1[$], input bit l1[$]);
    int p0 = 0;
    int p1 = 0;
    int pick;
    while (p0 < b0.size() || p1 < b1.size()) begin
      if (p0 < b0.size() && p1 < b1.size()) pick = (model_ls == 1) ? 0 : 1;
      else pick = (p0 < b0.size()) ? 0 : 1;
      if (pick == 0) begin
        do begin push_exp(0, b0[p0]); p0++; end while (!l0[p0-1]);
      end else begin
        do begin push_exp(1, b1[p1]); p1++; end while (!l1[p1-1]);
      end
      model_ls = pick;
    end
  endtask

  task automatic set_req(input int r, input bit v, input logic [7:0] d, input bit l);
    if (r == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
    else begin req1_valid = v; req1_data = d; req1_last = l; end
  endtask

  function automatic bit rdy(input int r);
    return (r == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic wait_ready(input int r);
    int n = 0;
    while (!rdy(r)) begin
      @(negedge clk);
      n++;
      if (n > 400) begin fail("ready_wait"); return; end
    end
  endtask

  task automatic drive_stream(input int r, input logic [7:0] b[$], input bit l[$], input int s[$]);
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0 && !l[i-1] && s[i] > 0) begin
        set_req(r, 1'b0, 8'h00, 1'b0);
        repeat (s[i]) @(negedge clk);
      end
      set_req(r, 1'b1, b[i], l[i]);
      wait_ready(r);
      @(negedge clk);
    end
    set_req(r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail("idle_wait");
  endtask

  initial begin : monitor
    exp_t e;
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_start) begin
          if (prev) fail("tx_start_width");
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_tx_start: got data %0h, nothing expected", tx_dato_in);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_dato_in, e.d);
            chk("tx_grant", grant, e.g);
          end
        end
        if (req0_ready) chk("ready0_owner", grant, 2'b01);
        if (req1_ready) chk("ready1_owner", grant, 2'b10);
      end
      prev = tx_start;
    end
  end

  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (tx_start && !tx_mute && !reset) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        tx_done_m = 1'b1;
        @(negedge clk);
        tx_done_m = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] b0[$], b1[$];
    bit         l0[$], l1[$];
    int         s0[$], s1[$];

    reset = 1'b1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_dato_in, 8'h00);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    model_ls = 1;
    @(negedge clk);

    // single 1-byte frame
    b0 = {8'hA5}; l0 = {1'b1}; s0 = {0};
    b1 = {}; l1 = {};
    model_order(b0, l0, b1, l1);
    drive_stream(0, b0, l0, s0);
    wait_idle();
    chk("t1_grant_after", grant, 2'b00);
    chk("t1_busy_after", busy, 1'b0);

    // 3-byte req0 frame while req1 waits
    push_exp(0, 8'h10); push_exp(0, 8'h20); push_exp(0, 8'h30);
    push_exp(1, 8'h77);
    model_ls = 1;
    b0 = {8'h10, 8'h20, 8'h30}; l0 = {1'b0, 1'b0, 1'b1}; s0 = {0, 0, 0};
    b1 = {8'h77}; l1 = {1'b1}; s1 = {0};
    fork
      drive_stream(0, b0, l0, s0);
      begin @(negedge clk); drive_stream(1, b1, l1, s1); end
    join
    wait_idle();

    // owner stalls 20 cycles in FETCH
    push_exp(0, 8'hB1); push_exp(0, 8'hB2);
    model_ls = 0;
    set_req(0, 1'b1, 8'hB1, 1'b0);
    wait_ready(0);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_ready(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_ready", req0_ready, 1'b1);
    end
    chk("stall_no_abort", timeout_err, 1'b0);
    set_req(0, 1'b1, 8'hB2, 1'b1);
    wait_ready(0);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_idle();

    // stray tx_done in IDLE and in FETCH
    tx_done_s = 1'b1;
    @(negedge clk);
    tx_done_s = 1'b0;
    @(negedge clk);
    chk("stray_idle_busy", busy, 1'b0);
    set_req(0, 1'b1, 8'hC3, 1'b1);
    @(negedge clk);
    chk("stray_fetch_ready", req0_ready, 1'b1);
    set_req(0, 1'b0, 8'h00, 1'b0);
    tx_done_s = 1'b1;
    @(negedge clk);
    tx_done_s = 1'b0;
    chk("stray_fetch_state", {busy, req0_ready, tx_start}, 3'b110);
    push_exp(0, 8'hC3);
    model_ls = 0;
    set_req(0, 1'b1, 8'hC3, 1'b1);
    wait_ready(0);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_idle();

    // timeout: tx_done never arrives
    tx_mute = 1'b1;
    push_exp(0, 8'h5A);
    model_ls = 0;
    set_req(0, 1'b1, 8'h5A, 1'b1);
    wait_ready(0);
    @(negedge clk);
    chk("to_start_seen", tx_start, 1'b1);
    set_req(0, 1'b0, 8'h00, 1'b0);
    repeat (TO) @(negedge clk);
    chk("to_not_early_busy", busy, 1'b1);
    chk("to_not_early_err", timeout_err, 1'b0);
    @(negedge clk);
    chk("to_grant", grant, 2'b00);
    chk("to_err_set", timeout_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    tx_mute = 1'b0;
    b0 = {}; l0 = {};
    b1 = {8'h66}; l1 = {1'b1}; s1 = {0};
    model_order(b0, l0, b1, l1);
    drive_stream(1, b1, l1, s1);
    wait_idle();
    chk("to_err_sticky", timeout_err, 1'b1);

    // reset during WAIT
    tx_mute = 1'b1;
    push_exp(0, 8'h99);
    set_req(0, 1'b1, 8'h99, 1'b1);
    wait_ready(0);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("wait_before_reset", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_grant", grant, 2'b00);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_tx_start", tx_start, 1'b0);
    chk("rstw_tx_data", tx_dato_in, 8'h00);
    chk("rstw_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rstw_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    tx_mute = 1'b0;
    model_ls = 1;
    @(negedge clk);

    // simultaneous request right after reset: req0 first
    b0 = {8'h31, 8'h32}; l0 = {1'b0, 1'b1}; s0 = {0, 0};
    b1 = {8'h41}; l1 = {1'b1}; s1 = {0};
    model_order(b0, l0, b1, l1);
    fork
      drive_stream(0, b0, l0, s0);
      drive_stream(1, b1, l1, s1);
    join
    wait_idle();

    // randomized rounds, both requesters kept busy
    for (int rnd = 0; rnd < 8; rnd++) begin
      b0 = {}; l0 = {}; s0 = {};
      b1 = {}; l1 = {}; s1 = {};
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        int nb = $urandom_range(1, 4);
        for (int k = 0; k < nb; k++) begin
          b0.push_back(8'($urandom)); l0.push_back(k == nb - 1);
          s0.push_back((k > 0) ? int'($urandom_range(0, 5)) : 0);
        end
      end
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        int nb = $urandom_range(1, 4);
        for (int k = 0; k < nb; k++) begin
          b1.push_back(8'($urandom)); l1.push_back(k == nb - 1);
          s1.push_back((k > 0) ? int'($urandom_range(0, 5)) : 0);
        end
      end
      model_order(b0, l0, b1, l1);
      fork
        drive_stream(0, b0, l0, s0);
        drive_stream(1, b1, l1, s1);
      join
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_err_clear", timeout_err, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
